// File: rtl/snake_body_tracker_pkg.sv
// Shared encodings for the snake body tracker: directions, controller states
// and the reset snake placement.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        CHECK = 2'b10,
        DEAD  = 2'b11
    } state_t;

    localparam logic [9:0] RST_HEAD_X = 10'd320;
    localparam logic [9:0] RST_HEAD_Y = 10'd240;
    localparam logic [6:0] RST_LENGTH = 7'd3;

    // Opposite directions differ only in the MSB of the encoding.
    function automatic logic is_reverse(input logic [1:0] req, input logic [1:0] cur);
        return (req ^ cur) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// Game-side bundle of the snake body tracker: move/grow requests, scan pixel in,
// head/length/status and on_body out.
interface snake_body_tracker_if;
    logic       move_tick;
    logic [1:0] dir;
    logic       grow;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [6:0] length;
    logic       busy;
    logic       self_hit;
    logic       wall_hit;
    logic       dead;
    logic       on_body;

    modport master (
        output move_tick, dir, grow, pixel_x, pixel_y,
        input  head_x, head_y, length, busy, self_hit, wall_hit, dead, on_body
    );

    modport slave (
        input  move_tick, dir, grow, pixel_x, pixel_y,
        output head_x, head_y, length, busy, self_hit, wall_hit, dead, on_body
    );
endinterface

// File: rtl/snake_body_tracker_coord_cell_match.sv
// Tests whether one scan pixel falls inside one STEP x STEP segment cell.
module coord_cell_match #(
    parameter int STEP = 10
) (
    input  logic [9:0] seg_x,
    input  logic [9:0] seg_y,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       hit
);
    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [10:0] sx, sy, px, py;

    // 11-bit operands keep seg + STEP from wrapping at the top of the range.
    always_comb begin
        sx  = {1'b0, seg_x};
        sy  = {1'b0, seg_y};
        px  = {1'b0, pixel_x};
        py  = {1'b0, pixel_y};
        hit = (px >= sx) && (px < sx + STEP11) && (py >= sy) && (py < sy + STEP11);
    end
endmodule

// File: rtl/snake_body_tracker.sv
// Snake segment store with move/grow, wall and self-collision checks and a
// pixel-on-body flag. Define SNAKE_WRAP_EN to wrap at the walls instead of dying.
module snake_body_tracker
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int STEP    = 10,
    parameter int X_MAX   = 640,
    parameter int Y_MAX   = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    snake_body_tracker_if.slave  bus
);
    localparam int          IDX_W  = $clog2(MAX_LEN);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] X11    = 11'(X_MAX);
    localparam logic [10:0] Y11    = 11'(Y_MAX);

    state_t       state_q, state_d;
    logic [9:0]   seg_x_q [MAX_LEN];
    logic [9:0]   seg_y_q [MAX_LEN];
    logic [9:0]   seg_x_d [MAX_LEN];
    logic [9:0]   seg_y_d [MAX_LEN];
    logic [6:0]   len_q, len_d;
    logic [6:0]   k_q, k_d;
    logic [1:0]   dir_q, dir_d;
    logic         pend_q, pend_d;
    logic         self_q, self_d;
    logic         wall_q, wall_d;
    logic         on_body_q, on_body_d;

    logic [10:0]  hx, hy;
    logic [9:0]   next_x, next_y;
    logic         at_edge, wall_stop;
    logic [MAX_LEN-1:0] cell_hit;

    // Candidate head position; at_edge marks a step that would leave the field.
    always_comb begin
        hx      = {1'b0, seg_x_q[0]};
        hy      = {1'b0, seg_y_q[0]};
        next_x  = seg_x_q[0];
        next_y  = seg_y_q[0];
        at_edge = 1'b0;
        case (dir_q)
            DIR_UP: begin
                at_edge = hy < STEP11;
                next_y  = at_edge ? 10'(Y_MAX - STEP) : seg_y_q[0] - 10'(STEP);
            end
            DIR_RIGHT: begin
                at_edge = (hx + STEP11) >= X11;
                next_x  = at_edge ? 10'd0 : seg_x_q[0] + 10'(STEP);
            end
            DIR_DOWN: begin
                at_edge = (hy + STEP11) >= Y11;
                next_y  = at_edge ? 10'd0 : seg_y_q[0] + 10'(STEP);
            end
            DIR_LEFT: begin
                at_edge = hx < STEP11;
                next_x  = at_edge ? 10'(X_MAX - STEP) : seg_x_q[0] - 10'(STEP);
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_stop = 1'b0;
`else
    assign wall_stop = at_edge;
`endif

    always_comb begin
        state_d = state_q;
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        len_d   = len_q;
        k_d     = k_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        self_d  = self_q;
        wall_d  = wall_q;
        case (state_q)
            IDLE: begin
                if (bus.move_tick) begin
                    state_d = SHIFT;
                    if (!is_reverse(bus.dir, dir_q)) dir_d = bus.dir;
                end
            end
            SHIFT: begin
                if (wall_stop) begin
                    wall_d  = 1'b1;
                    state_d = DEAD;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = next_x;
                    seg_y_d[0] = next_y;
                    if (pend_q) begin
                        pend_d = 1'b0;
                        if (len_q < 7'(MAX_LEN)) len_d = len_q + 7'd1;
                    end
                    k_d     = 7'd1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (seg_x_q[0] == seg_x_q[k_q[IDX_W-1:0]] &&
                    seg_y_q[0] == seg_y_q[k_q[IDX_W-1:0]]) begin
                    self_d  = 1'b1;
                    state_d = DEAD;
                end else if (k_q == len_q - 7'd1) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            DEAD: begin
            end
        endcase
        // A grow arriving during SHIFT re-arms pending after it is consumed.
        if (bus.grow && state_q != DEAD) pend_d = 1'b1;
    end

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_cell
        logic match;
        coord_cell_match #(.STEP(STEP)) u_match (
            .seg_x   (seg_x_q[i]),
            .seg_y   (seg_y_q[i]),
            .pixel_x (bus.pixel_x),
            .pixel_y (bus.pixel_y),
            .hit     (match)
        );
        assign cell_hit[i] = match && (7'(i) < len_q);
    end

    assign on_body_d = |cell_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= RST_LENGTH;
            k_q       <= 7'd1;
            dir_q     <= DIR_RIGHT;
            pend_q    <= 1'b0;
            self_q    <= 1'b0;
            wall_q    <= 1'b0;
            on_body_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < int'(RST_LENGTH)) begin
                    seg_x_q[i] <= RST_HEAD_X - 10'(i * STEP);
                    seg_y_q[i] <= RST_HEAD_Y;
                end else begin
                    seg_x_q[i] <= 10'd0;
                    seg_y_q[i] <= 10'd0;
                end
            end
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            k_q       <= k_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            self_q    <= self_d;
            wall_q    <= wall_d;
            on_body_q <= on_body_d;
            seg_x_q   <= seg_x_d;
            seg_y_q   <= seg_y_d;
        end
    end

    assign bus.head_x   = seg_x_q[0];
    assign bus.head_y   = seg_y_q[0];
    assign bus.length   = len_q;
    assign bus.busy     = (state_q == SHIFT) || (state_q == CHECK);
    assign bus.dead     = (state_q == DEAD);
    assign bus.self_hit = self_q;
    assign bus.wall_hit = wall_q;
    assign bus.on_body  = on_body_q;
endmodule
